// File: rtl/uart_pkg.sv
// Shared constants for the UART button receiver: FSM encodings, ASCII keys,
// button codes and the key-to-button decode used by the game front end.
package uart_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    localparam logic [7:0] KEY_D_LO = 8'h64;
    localparam logic [7:0] KEY_D_UP = 8'h44;
    localparam logic [7:0] KEY_A_LO = 8'h61;
    localparam logic [7:0] KEY_A_UP = 8'h41;
    localparam logic [7:0] KEY_W_LO = 8'h77;
    localparam logic [7:0] KEY_W_UP = 8'h57;
    localparam logic [7:0] KEY_S_LO = 8'h73;
    localparam logic [7:0] KEY_S_UP = 8'h53;

    localparam logic [3:0] BTN_NONE       = 4'b0000;
    localparam logic [3:0] BTN_RIGHT      = 4'b0001;
    localparam logic [3:0] BTN_LEFT       = 4'b1000;
    localparam logic [3:0] BTN_CYCLE_FWD  = 4'b0100;
    localparam logic [3:0] BTN_CYCLE_BACK = 4'b0010;

    function automatic logic [3:0] key_decode(input logic [7:0] key);
        logic [3:0] btn;
        case (key)
            KEY_D_LO, KEY_D_UP: btn = BTN_RIGHT;
            KEY_A_LO, KEY_A_UP: btn = BTN_LEFT;
            KEY_W_LO, KEY_W_UP: btn = BTN_CYCLE_FWD;
            KEY_S_LO, KEY_S_UP: btn = BTN_CYCLE_BACK;
            default:            btn = BTN_NONE;
        endcase
        return btn;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM and LSB-first
// shift register. A low stop bit parks the FSM until the line returns high.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       frame_done,
    output logic [7:0] frame_data
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic          rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    byte_q, byte_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned, which would infer a latch.
        rx_meta_d  = rx_i;
        rx_sync_d  = rx_meta_q;
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_d     = byte_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_sync_q) begin
                    state_d = ST_START;
                    bit_d   = 3'd0;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_sync_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_sync_q) begin
                        frame_done = 1'b1;
                        valid_d    = 1'b1;
                        byte_d     = shift_q;
                        state_d    = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_sync_q) state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            shift_q   <= 8'h00;
            byte_q    <= 8'h00;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx_meta_d;
            rx_sync_q <= rx_sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    assign rx_byte    = byte_q;
    assign rx_valid   = valid_q;
    assign frame_err  = ferr_q;
    assign frame_data = shift_q;

endmodule

// File: rtl/uart_button_rx.sv
// UART-to-button front end: receives bytes and turns movement keys into
// single-cycle one-hot button codes aligned with rx_valid.
module uart_button_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [3:0] button,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err
);

    logic       frame_done;
    logic [7:0] frame_data;
    logic [3:0] button_q, button_d;

    uart_rx_core #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .rx_i       (rx_i),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .frame_done (frame_done),
        .frame_data (frame_data)
    );

    // Decode from the pre-register strobe so button lands in the rx_valid cycle.
    always_comb begin
        button_d = frame_done ? key_decode(frame_data) : BTN_NONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) button_q <= BTN_NONE;
        else     button_q <= button_d;
    end

    assign button = button_q;

endmodule

// File: tb/tb_uart_button_rx.sv
// Directed bench for uart_button_rx at 10 clocks per bit: key decode,
// back-to-back frames, framing error, glitch rejection and mid-frame reset.
module tb_uart_button_rx;
    import uart_pkg::*;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int CPB    = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_i = 1'b1;
    logic [3:0] button;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_err;

    int total = 0;
    int bad   = 0;

    int cyc = 0, valid_cnt = 0, btn_cnt = 0, ferr_cnt = 0, btn_bad = 0;
    logic [7:0] hist_byte [256];
    logic [3:0] hist_btn  [256];
    int         hist_cyc  [256];
    int t0, v0, b0, f0;

    logic [7:0] keys [5] = '{8'h44, 8'h61, 8'h57, 8'h53, 8'h30};
    logic [3:0] btns [5] = '{4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0000};

    always #5 clk = ~clk;

    uart_button_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .rx_i      (rx_i),
        .button    (button),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .frame_err (frame_err)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            hist_byte[valid_cnt[7:0]] <= rx_byte;
            hist_btn[valid_cnt[7:0]]  <= button;
            hist_cyc[valid_cnt[7:0]]  <= cyc;
            valid_cnt <= valid_cnt + 1;
        end
        if (button != 4'b0000) btn_cnt <= btn_cnt + 1;
        if ((button != 4'b0000 && !rx_valid) || $countones(button) > 1) btn_bad <= btn_bad + 1;
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop);
        t0 = cyc;
        rx_i = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_i = data[i];
            repeat (CPB) @(negedge clk);
        end
        rx_i = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx_i = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        v0 = valid_cnt;
        b0 = btn_cnt;
        f0 = ferr_cnt;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_button", {28'd0, button}, 32'h0);
        check("rst_byte", {24'd0, rx_byte}, 32'h0);
        check("rst_valid", {31'd0, rx_valid}, 32'h0);
        check("rst_ferr", {31'd0, frame_err}, 32'h0);
        rst = 1'b0;
        idle(5);

        // 'd' with latency: 2 sync + 5 half bit + 90 + 1 register = 98 edges
        snap();
        send_frame(8'h64, 1'b1);
        idle(20);
        check("d_valid_cnt", valid_cnt - v0, 1);
        check("d_byte", {24'd0, hist_byte[v0]}, 32'h64);
        check("d_button", {28'd0, hist_btn[v0]}, 32'h1);
        check("d_btn_cycles", btn_cnt - b0, 1);
        check("d_ferr", ferr_cnt - f0, 0);
        check("d_latency_ok", {31'd0, (hist_cyc[v0] - t0 >= 97) && (hist_cyc[v0] - t0 <= 99)}, 1);
        check("d_byte_held", {24'd0, rx_byte}, 32'h64);

        snap();
        send_frame(8'h41, 1'b1);
        send_frame(8'h78, 1'b1);
        idle(20);
        check("b2b_valid_cnt", valid_cnt - v0, 2);
        check("b2b_byte0", {24'd0, hist_byte[v0]}, 32'h41);
        check("b2b_btn0", {28'd0, hist_btn[v0]}, 32'h8);
        check("b2b_byte1", {24'd0, hist_byte[v0+1]}, 32'h78);
        check("b2b_btn1", {28'd0, hist_btn[v0+1]}, 32'h0);
        check("b2b_btn_cycles", btn_cnt - b0, 1);

        snap();
        send_frame(8'h77, 1'b0);
        repeat (30) @(negedge clk);
        idle(20);
        check("ferr_cnt", ferr_cnt - f0, 1);
        check("ferr_no_valid", valid_cnt - v0, 0);
        check("ferr_no_button", btn_cnt - b0, 0);
        check("ferr_byte_kept", {24'd0, rx_byte}, 32'h78);
        snap();
        send_frame(8'h73, 1'b1);
        idle(20);
        check("after_ferr_valid", valid_cnt - v0, 1);
        check("after_ferr_byte", {24'd0, hist_byte[v0]}, 32'h73);
        check("after_ferr_btn", {28'd0, hist_btn[v0]}, 32'h2);

        snap();
        rx_i = 1'b0;
        repeat (3) @(negedge clk);
        idle(20);
        check("glitch_valid", valid_cnt - v0, 0);
        check("glitch_button", btn_cnt - b0, 0);
        check("glitch_ferr", ferr_cnt - f0, 0);
        check("glitch_idle", {29'd0, u_dut.u_core.state_q}, {29'd0, ST_IDLE});

        for (int k = 0; k < 5; k++) begin
            snap();
            send_frame(keys[k], 1'b1);
            idle(20);
            check("key_byte", {24'd0, hist_byte[v0]}, {24'd0, keys[k]});
            check("key_button", {28'd0, hist_btn[v0]}, {28'd0, btns[k]});
        end

        // Reset lands in data bit 2 and releases during the high stop bit.
        snap();
        fork
            send_frame(8'h57, 1'b1);
            begin
                repeat (35) @(negedge clk);
                rst = 1'b1;
                repeat (2) @(negedge clk);
                check("mid_rst_button", {28'd0, button}, 32'h0);
                check("mid_rst_byte", {24'd0, rx_byte}, 32'h0);
                check("mid_rst_valid", {31'd0, rx_valid}, 32'h0);
                check("mid_rst_ferr", {31'd0, frame_err}, 32'h0);
                repeat (55) @(negedge clk);
                rst = 1'b0;
            end
        join
        idle(20);
        check("mid_rst_no_valid", valid_cnt - v0, 0);
        check("mid_rst_no_ferr", ferr_cnt - f0, 0);
        snap();
        send_frame(8'h57, 1'b1);
        idle(20);
        check("post_rst_valid", valid_cnt - v0, 1);
        check("post_rst_byte", {24'd0, hist_byte[v0]}, 32'h57);
        check("post_rst_btn", {28'd0, hist_btn[v0]}, 32'h4);

        check("button_only_with_valid", btn_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
